// File: rtl/ctrl_ringbuf_seq_if.sv
// Handshake and bus bundle between the ring-buffer sequencer, its clients,
// the data RAM write port and the ring-buffer address driver.
interface ctrl_ringbuf_seq_if #(
    parameter int AW = 8,
    parameter int OW = 8
);
    logic [AW-1:0] cfg_uptr;
    logic [AW-1:0] cfg_lptr;
    logic          wr_req;
    logic          wr_ack;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic          calc_req;
    logic          calc_ack;
    logic          calc_done;
    logic          tap_valid;
    logic          tap_ready;
    logic [AW-1:0] tap_addr;
    logic          tap_last;
    logic          rb_init;
    logic          rb_cnt;
    logic [AW-1:0] rb_uptr;
    logic [AW-1:0] rb_lptr;
    logic [OW-1:0] rb_head_offset;
    logic          rb_finish_f;
    logic [AW-1:0] rb_addr;

    // Environment side: clients, tap consumer and ring-buffer driver
    modport master (
        output cfg_uptr, cfg_lptr, wr_req, calc_req, tap_ready, rb_finish_f, rb_addr,
        input  wr_ack, ram_we, ram_waddr, calc_ack, calc_done, tap_valid, tap_addr,
               tap_last, rb_init, rb_cnt, rb_uptr, rb_lptr, rb_head_offset
    );

    // Sequencer side
    modport slave (
        input  cfg_uptr, cfg_lptr, wr_req, calc_req, tap_ready, rb_finish_f, rb_addr,
        output wr_ack, ram_we, ram_waddr, calc_ack, calc_done, tap_valid, tap_addr,
               tap_last, rb_init, rb_cnt, rb_uptr, rb_lptr, rb_head_offset
    );
endinterface

// File: rtl/ctrl_ringbuf_seq.sv
// Ring-buffer sequencer: arbitrates between new-sample writes and tap walks
// over a circular window [uptr, lptr] of the data RAM. Writes advance the
// head offset; a tap walk presents addresses newest-first down to the oldest.
package ctrl;
    localparam int DATA_RAM_ADDRESS_WIDTH = 8;
    localparam int DATA_OFFSET_WIDTH      = 8;
endpackage

module ctrl_ringbuf_seq #(
    parameter int DATA_ADDRESS_WIDTH = ctrl::DATA_RAM_ADDRESS_WIDTH,
    parameter int DATA_OFFSET_WIDTH  = ctrl::DATA_OFFSET_WIDTH
) (
    input logic               clk,
    input logic               clr_n,
    ctrl_ringbuf_seq_if.slave bus
);
    localparam int AW = DATA_ADDRESS_WIDTH;
    localparam int OW = DATA_OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        INIT,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [OW-1:0] head_off;
    logic [OW-1:0] head_next;
    logic [AW-1:0] head_addr;
    logic [AW-1:0] uptr_q;
    logic [AW-1:0] lptr_q;
    logic          last_grant_wr;
    logic          grant_wr;
    logic          grant_calc;

    assign bus.rb_uptr = uptr_q;
    assign bus.rb_lptr = lptr_q;

    // Next head offset: wrap to the window start once the head sits on the last address
    always_comb begin
        head_addr = uptr_q + AW'(head_off);
        if (head_addr >= lptr_q) begin
            head_next = '0;
        end else begin
            head_next = head_off + OW'(1);
        end
    end

    // Round-robin arbitration: with both requests pending, the side not granted last wins
    always_comb begin
        grant_wr   = bus.wr_req & (~bus.calc_req | ~last_grant_wr);
        grant_calc = bus.calc_req & ~grant_wr;
    end

    // State, head offset, captured window and arbitration history
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state         <= IDLE;
            head_off      <= '0;
            uptr_q        <= '0;
            lptr_q        <= '0;
            last_grant_wr <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                uptr_q <= bus.cfg_uptr;
                lptr_q <= bus.cfg_lptr;
                if (grant_wr) begin
                    last_grant_wr <= 1'b1;
                end else if (grant_calc) begin
                    last_grant_wr <= 1'b0;
                end
            end
            if (state == WRITE) begin
                head_off <= head_next;
            end
        end
    end

    // Next-state decode and per-state strobes; everything idles at zero
    always_comb begin
        state_next         = state;
        bus.wr_ack         = 1'b0;
        bus.ram_we         = 1'b0;
        bus.ram_waddr      = '0;
        bus.calc_ack       = 1'b0;
        bus.calc_done      = 1'b0;
        bus.tap_valid      = 1'b0;
        bus.tap_addr       = '0;
        bus.tap_last       = 1'b0;
        bus.rb_init        = 1'b0;
        bus.rb_cnt         = 1'b0;
        bus.rb_head_offset = '0;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_next = WRITE;
                end else if (grant_calc) begin
                    state_next = INIT;
                end
            end
            WRITE: begin
                bus.wr_ack    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_waddr = uptr_q + AW'(head_next);
                state_next    = IDLE;
            end
            INIT: begin
                bus.calc_ack       = 1'b1;
                bus.rb_init        = 1'b1;
                bus.rb_head_offset = head_off;
                state_next         = RUN;
            end
            RUN: begin
                bus.tap_valid = 1'b1;
                bus.tap_addr  = bus.rb_addr;
                bus.tap_last  = bus.rb_finish_f;
                bus.rb_cnt    = bus.tap_ready & ~bus.rb_finish_f;
                if (bus.tap_ready && bus.rb_finish_f) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.calc_done = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ctrl_ringbuf_seq.sv
// Bench for the ring-buffer sequencer: a small ring-buffer driver model,
// a scoreboard queue filled by the stimulus, and a monitor popping it.
module tb_ctrl_ringbuf_seq;
    localparam int AW = 8;
    localparam int OW = 8;
    localparam int OP_WRITE = 0;
    localparam int OP_CALC  = 1;

    typedef enum int {K_WR, K_CACK, K_TAP, K_DONE} kind_t;
    typedef struct {
        kind_t         kind;
        logic [AW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic clk    = 1'b0;
    logic clr_n  = 1'b0;

    ctrl_ringbuf_seq_if #(.AW(AW), .OW(OW)) bus();

    ctrl_ringbuf_seq #(
        .DATA_ADDRESS_WIDTH(AW),
        .DATA_OFFSET_WIDTH(OW)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Ring-buffer driver model: loads head/tail on init, steps down with wrap on cnt
    logic [AW-1:0] drv_addr;
    logic [AW-1:0] drv_tail;
    logic [AW-1:0] drv_head;
    always @(posedge clk) begin
        drv_head = bus.rb_uptr + AW'(bus.rb_head_offset);
        if (!clr_n) begin
            drv_addr <= '0;
            drv_tail <= '0;
        end else if (bus.rb_init) begin
            drv_addr <= drv_head;
            drv_tail <= (drv_head == bus.rb_lptr) ? bus.rb_uptr : drv_head + AW'(1);
        end else if (bus.rb_cnt) begin
            drv_addr <= (drv_addr == bus.rb_uptr) ? bus.rb_lptr : drv_addr - AW'(1);
        end
    end
    assign bus.rb_addr     = drv_addr;
    assign bus.rb_finish_f = (drv_addr == drv_tail);

    // Queue one expected DUT event
    task automatic expect_item(input kind_t k, input logic [AW-1:0] d, input logic l);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Queue a full tap walk: calc_ack with head offset, n taps, then calc_done
    task automatic expect_calc(input logic [AW-1:0] hoff, input int n,
                               input logic [AW-1:0] t0, input logic [AW-1:0] t1,
                               input logic [AW-1:0] t2, input logic [AW-1:0] t3);
        logic [AW-1:0] taps [4];
        taps[0] = t0;
        taps[1] = t1;
        taps[2] = t2;
        taps[3] = t3;
        expect_item(K_CACK, hoff, 1'b0);
        for (int i = 0; i < n; i++) begin
            expect_item(K_TAP, taps[i], (i == n - 1));
        end
        expect_item(K_DONE, '0, 1'b0);
    endtask

    // Direct comparison against a hand-computed value
    task automatic checkValue(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    // Scoreboard compare for one observed DUT event
    task automatic checkOutput(input kind_t kind, input logic [AW-1:0] data, input logic last);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_%s: got data=%h last=%b, required no event",
                     kind.name(), data, last);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data || e.last != last) begin
                errors++;
                $display("[TB] FAIL event_%s: got kind=%s data=%h last=%b, required kind=%s data=%h last=%b",
                         e.kind.name(), kind.name(), data, last, e.kind.name(), e.data, e.last);
            end
        end
    endtask

    // Monitor: sample at the falling edge and pop the scoreboard for every presented event
    always @(negedge clk) begin
        if (bus.wr_ack || bus.ram_we) begin
            checkValue("ram_we_eq_wr_ack", int'(bus.ram_we), int'(bus.wr_ack));
            checkOutput(K_WR, bus.ram_waddr, 1'b0);
        end
        if (bus.calc_ack || bus.rb_init) begin
            checkValue("rb_init_eq_calc_ack", int'(bus.rb_init), int'(bus.calc_ack));
            checkOutput(K_CACK, AW'(bus.rb_head_offset), 1'b0);
        end
        if (bus.tap_valid && bus.tap_ready) begin
            checkOutput(K_TAP, bus.tap_addr, bus.tap_last);
        end
        if (bus.calc_done) begin
            checkOutput(K_DONE, '0, 1'b0);
        end
        if (bus.rb_init || bus.rb_cnt) begin
            checkValue("init_cnt_exclusive", int'(bus.rb_init && bus.rb_cnt), 0);
        end
    end

    // One write or one tap walk, optionally stalling tap_ready for 3 cycles after stall_after taps
    task automatic applyStimulus(input int op, input int stall_after,
                                 input logic [AW-1:0] stall_addr, input int n_taps);
        int  cyc;
        int  accepted;
        int  stalled;
        int  first_valid;
        bit  acked;
        bit  done;
        cyc   = 0;
        acked = 1'b0;
        if (op == OP_WRITE) bus.wr_req = 1'b1;
        else bus.calc_req = 1'b1;
        while (!acked && cyc < 20) begin
            @(posedge clk); #2;
            cyc++;
            acked = (op == OP_WRITE) ? bus.wr_ack : bus.calc_ack;
        end
        bus.wr_req   = 1'b0;
        bus.calc_req = 1'b0;
        if (!acked) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: got no grant in %0d cycles, required grant", cyc);
            return;
        end
        checkValue("grant_latency", cyc, 1);
        if (op == OP_CALC) begin
            accepted    = 0;
            stalled     = 0;
            first_valid = -1;
            done        = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(posedge clk); #2;
                if (bus.calc_done) begin
                    done = 1'b1;
                end else if (bus.tap_valid) begin
                    if (first_valid < 0) first_valid = c;
                    if (accepted == stall_after && stalled < 3) begin
                        bus.tap_ready = 1'b0;
                        #1;
                        checkValue("stall_tap_addr", int'(bus.tap_addr), int'(stall_addr));
                        checkValue("stall_rb_cnt", int'(bus.rb_cnt), 0);
                        stalled++;
                    end else begin
                        bus.tap_ready = 1'b1;
                        accepted++;
                    end
                end
            end
            bus.tap_ready = 1'b0;
            checkValue("first_tap_latency", first_valid, 0);
            checkValue("tap_count", accepted, n_taps);
            if (!done) begin
                checks++;
                errors++;
                $display("[TB] FAIL done_timeout: got no calc_done, required calc_done");
            end
        end
        @(posedge clk); #2;
    endtask

    // Directed sequence
    initial begin
        int wcnt;
        int ccnt;
        int dcnt;
        bit ok;
        bus.cfg_uptr  = 8'h10;
        bus.cfg_lptr  = 8'h13;
        bus.wr_req    = 1'b0;
        bus.calc_req  = 1'b0;
        bus.tap_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("reset_rb_uptr", int'(bus.rb_uptr), 0);
        checkValue("reset_rb_lptr", int'(bus.rb_lptr), 0);
        checkValue("reset_wr_ack", int'(bus.wr_ack), 0);
        checkValue("reset_tap_valid", int'(bus.tap_valid), 0);
        checkValue("reset_calc_done", int'(bus.calc_done), 0);
        @(posedge clk); #2;
        clr_n = 1'b1;
        @(posedge clk); #2;
        checkValue("idle_rb_uptr", int'(bus.rb_uptr), 'h10);
        checkValue("idle_rb_lptr", int'(bus.rb_lptr), 'h13);

        // First write lands at offset 1, then a full walk from head 0x11
        expect_item(K_WR, 8'h11, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);
        expect_calc(8'd1, 4, 8'h11, 8'h10, 8'h13, 8'h12);
        applyStimulus(OP_CALC, -1, '0, 4);

        // Advance head to 3, then four writes wrap through offset 0
        expect_item(K_WR, 8'h12, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);
        expect_item(K_WR, 8'h13, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);
        expect_item(K_WR, 8'h10, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);
        expect_item(K_WR, 8'h11, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);
        expect_item(K_WR, 8'h12, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);
        expect_item(K_WR, 8'h13, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);

        // Walk from head 0x13 with a 3-cycle consumer stall after two taps
        expect_calc(8'd3, 4, 8'h13, 8'h12, 8'h11, 8'h10);
        applyStimulus(OP_CALC, 2, 8'h11, 4);

        // Reset mid-RUN aborts the walk with no calc_done
        expect_item(K_CACK, 8'd3, 1'b0);
        bus.calc_req = 1'b1;
        @(posedge clk); #2;
        bus.calc_req = 1'b0;
        checkValue("abort_calc_ack", int'(bus.calc_ack), 1);
        repeat (2) @(posedge clk);
        #2;
        checkValue("abort_run_valid", int'(bus.tap_valid), 1);
        clr_n = 1'b0;
        @(posedge clk); #2;
        checkValue("abort_tap_valid", int'(bus.tap_valid), 0);
        checkValue("abort_calc_done", int'(bus.calc_done), 0);
        checkValue("abort_wr_ack", int'(bus.wr_ack), 0);
        clr_n = 1'b1;
        @(posedge clk); #2;
        checkValue("after_abort_calc_done", int'(bus.calc_done), 0);

        // Single-entry window: head offset back at 0, one tap flagged last
        bus.cfg_uptr = 8'h20;
        bus.cfg_lptr = 8'h20;
        expect_calc(8'd0, 1, 8'h20, 8'h00, 8'h00, 8'h00);
        applyStimulus(OP_CALC, -1, '0, 1);
        expect_item(K_WR, 8'h20, 1'b0);
        applyStimulus(OP_WRITE, -1, '0, 0);

        // Both requests held from reset: write, calc, write, calc
        clr_n        = 1'b0;
        bus.cfg_uptr = 8'h10;
        bus.cfg_lptr = 8'h13;
        @(posedge clk); #2;
        clr_n = 1'b1;
        @(posedge clk); #2;
        expect_item(K_WR, 8'h11, 1'b0);
        expect_calc(8'd1, 4, 8'h11, 8'h10, 8'h13, 8'h12);
        expect_item(K_WR, 8'h12, 1'b0);
        expect_calc(8'd2, 4, 8'h12, 8'h11, 8'h10, 8'h13);
        wcnt          = 0;
        ccnt          = 0;
        dcnt          = 0;
        bus.tap_ready = 1'b1;
        bus.wr_req    = 1'b1;
        bus.calc_req  = 1'b1;
        for (int c = 0; c < 60 && dcnt < 2; c++) begin
            @(posedge clk); #2;
            if (c == 0) checkValue("both_first_wr_ack", int'(bus.wr_ack), 1);
            if (bus.wr_ack) begin
                wcnt++;
                if (wcnt == 2) bus.wr_req = 1'b0;
            end
            if (bus.calc_ack) begin
                ccnt++;
                if (ccnt == 2) bus.calc_req = 1'b0;
            end
            if (bus.calc_done) dcnt++;
        end
        bus.wr_req    = 1'b0;
        bus.calc_req  = 1'b0;
        bus.tap_ready = 1'b0;
        checkValue("alternation_done_count", dcnt, 2);
        repeat (3) @(posedge clk);
        #2;

        ok = (exp_q.size() == 0);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending events, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ctrl_ringbuf_seq.md
CTRL_RINGBUF_SEQ -- requirements
Module: ctrl_ringbuf_seq

Interface
REQ-001 SHALL have parameter DATA_ADDRESS_WIDTH, default ctrl::DATA_RAM_ADDRESS_WIDTH, data RAM address width (AW).
REQ-002 SHALL have parameter DATA_OFFSET_WIDTH, default ctrl::DATA_OFFSET_WIDTH, head offset width (OW).
REQ-003 SHALL have ports as follows, one clock, reset synchronous and active-low:
  clk             in   1   sole clock, all state on rising edge
  clr_n           in   1   synchronous active-low reset
  cfg_uptr        in   AW  ring buffer first address
  cfg_lptr        in   AW  ring buffer last address (cfg_uptr <= cfg_lptr)
  wr_req          in   1   new-sample write request, level, held until wr_ack
  wr_ack          out  1   one-cycle write grant
  ram_we          out  1   data RAM write enable
  ram_waddr       out  AW  data RAM write address
  calc_req        in   1   tap-walk request, level, held until calc_ack
  calc_ack        out  1   one-cycle calc grant
  calc_done       out  1   one-cycle pulse after last tap accepted
  tap_valid       out  1   tap_addr valid
  tap_ready       in   1   consumer accepts tap
  tap_addr        out  AW  current tap read address
  tap_last        out  1   current tap is the oldest sample
  rb_init         out  1   to ring buffer driver: load head/pointers
  rb_cnt          out  1   to ring buffer driver: step address
  rb_uptr         out  AW  captured first address
  rb_lptr         out  AW  captured last address
  rb_head_offset  out  OW  current head offset
  rb_finish_f     in   1   from driver: address equals tail
  rb_addr         in   AW  from driver: current address

Function
REQ-004 SHALL implement FSM states IDLE, WRITE, INIT, RUN, DONE.
REQ-005 IDLE: sample cfg_uptr/cfg_lptr into uptr_q/lptr_q every cycle; rb_uptr/rb_lptr SHALL drive uptr_q/lptr_q at all times.
REQ-006 IDLE arbitration: only wr_req -> WRITE; only calc_req -> INIT; both -> round-robin via last_grant flag (write wins first after reset, then alternate).
REQ-007 WRITE (one cycle): wr_ack=1, ram_we=1, ram_waddr=uptr_q+head_next; head_off <= head_next; -> IDLE.
REQ-008 head_next SHALL be 0 when uptr_q+head_off >= lptr_q, else head_off+1 (OW-bit, zero-extended to AW for addition, sum truncated to AW).
REQ-009 INIT (one cycle): calc_ack=1, rb_init=1, rb_head_offset=head_off; -> RUN.
REQ-010 RUN: tap_valid=1, tap_addr=rb_addr, tap_last=rb_finish_f, rb_cnt=tap_ready & ~rb_finish_f.
REQ-011 RUN with tap_ready=0 SHALL hold state and tap_addr unchanged (rb_cnt=0).
REQ-012 RUN with tap_ready=1 and rb_finish_f=1 -> DONE; otherwise stay RUN.
REQ-013 DONE (one cycle): calc_done=1; -> IDLE.
REQ-014 head_off, uptr_q, lptr_q SHALL be stable from INIT through DONE; wr_req arriving outside IDLE SHALL wait and be granted no earlier than the IDLE cycle following DONE.
REQ-015 Latency: request seen in IDLE at cycle N -> grant (wr_ack or calc_ack) at N+1; first tap_valid at N+2.
REQ-016 Tap count per calc SHALL equal lptr_q-uptr_q+1, newest (head) first, descending with wrap from uptr_q to lptr_q.
REQ-017 L=1 (uptr=lptr): single tap with tap_last=1 on first RUN cycle.
REQ-018 rb_init and rb_cnt SHALL never be asserted in the same cycle; all outputs not named active in a state SHALL be 0.

Reset
REQ-019 clr_n=0 at a rising edge SHALL force IDLE, head_off=0, last_grant=calc (write favored), uptr_q=lptr_q=0, all strobes 0.
REQ-020 Reset mid-WRITE/RUN SHALL abort without calc_done, wr_ack or ram_we in the following cycle.

Verification
REQ-021 uptr=0x10, lptr=0x13, after reset, wr_req 1 cycle -> wr_ack/ram_we next cycle, ram_waddr=0x11, head_off=1.
REQ-022 Then calc_req, tap_ready=1 -> calc_ack, taps 0x11,0x10,0x13,0x12, tap_last on 0x12, calc_done next cycle.
REQ-023 Four writes from head_off=3 -> ram_waddr 0x10,0x11,0x12,0x13 (wrap to offset 0).
REQ-024 wr_req and calc_req together from reset -> WRITE first, then INIT; repeat both held -> strict alternation.
REQ-025 tap_ready low 3 cycles mid-RUN -> tap_addr held, rb_cnt=0, tap count still 4.
REQ-026 clr_n low during RUN -> next cycle IDLE, tap_valid=0, no calc_done, head_off=0.
